// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// presents the latched word to the control unit. Optional macro: FETCH_MISALIGN_EN.
module fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            pcsrc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic            fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_EXEC} state_t;
`endif

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;

  logic [XLEN-1:0] branch_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;
  logic            misalign;
  logic            exec_go;

  assign branch_sum = pc_q + imm;
  assign target     = pcsrc ? branch_sum : pc_q + XLEN'(4);
  assign exec_go    = (state_q == S_EXEC) && !stall;

`ifdef FETCH_MISALIGN_EN
  assign misalign = pcsrc && (branch_sum[1:0] != 2'b00);
  assign pc_next  = target;
`else
  // Without fault reporting the target is simply word-aligned.
  assign misalign = 1'b0;
  assign pc_next  = target & ~XLEN'(3);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (imem_ready) state_d = S_EXEC;
      S_EXEC: begin
        if (!stall) begin
`ifdef FETCH_MISALIGN_EN
          state_d = misalign ? S_HALT : S_FETCH;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef FETCH_MISALIGN_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Datapath registers
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          instr_valid_d = 1'b0;
          if (!misalign) pc_d = pc_next;
        end
      end
      default: instr_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  logic fault_q, fault_d;

  assign fault_d = fault_q | (exec_go && misalign);

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Output logic: the request is dropped as soon as reset rises
  always_comb begin
    imem_req  = (state_q == S_FETCH) && !reset;
    imem_addr = pc_q;
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[30];

endmodule
